// File: rtl/adc_seq_pkg.sv
// Shared types, default widths and mask-scan helpers for the ADC scan sequencer.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int CH_W   = 5;
  localparam int DATA_W = 12;
  localparam int MASK_W = 32;

  // Lowest set bit at or above 'from'; returns MASK_W when none is left.
  function automatic logic [5:0] next_set_bit(input logic [MASK_W-1:0] mask,
                                               input logic [5:0]        from);
    logic [5:0] idx;
    idx = 6'd32;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i] && (6'(i) >= from)) idx = 6'(i);
    end
    return idx;
  endfunction

  // Highest set bit; 0 for an empty mask (callers never pass one).
  function automatic logic [5:0] last_set_bit(input logic [MASK_W-1:0] mask);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_scan_sequencer_fifo.sv
// Issue-order FIFO: remembers which channel each outstanding command asked for.
// Head is visible combinationally so a response can be checked in its own cycle.
module adc_chan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = adc_seq_pkg::CH_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Drives the ADC command stream over a channel mask, checks responses against
// issue order and keeps the latest sample of every channel in a result bank.
module adc_scan_sequencer #(
  parameter int NUM_CH  = 17,
  parameter int MAX_OUT = 4,
  parameter int CH_W    = adc_seq_pkg::CH_W,
  parameter int DATA_W  = adc_seq_pkg::DATA_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] chan_mask,
  output logic              cmd_valid,
  output logic [CH_W-1:0]   cmd_channel,
  output logic              cmd_sop,
  output logic              cmd_eop,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [CH_W-1:0]   rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              scan_done,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_channel,
  output logic [DATA_W-1:0] sample_data,
  output logic              err_mismatch,
  input  logic              err_clr,
  input  logic [CH_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  import adc_seq_pkg::*;

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   mask_reg, mask_next;
  logic [CH_W-1:0]     ptr_reg, ptr_next;
  logic [CH_W-1:0]     last_reg, last_next;
  logic                sop_reg, sop_next;

  logic [CH_W-1:0]     live_first;
  logic [CH_W-1:0]     live_last;
  logic [CH_W-1:0]     scan_next_ptr;
  logic                is_last;
  logic                cmd_fire;

  logic [CH_W-1:0]     fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                err_set;

  logic                sample_valid_reg;
  logic [CH_W-1:0]     sample_channel_reg;
  logic [DATA_W-1:0]   sample_data_reg;
  logic                err_reg;

  logic [DATA_W-1:0]   bank_reg [NUM_CH];
  logic [NUM_CH-1:0]   bank_we;
  logic                rsp_in_range;
  logic                rd_in_range;

  // Scan bounds of the live mask (used on start and on a continuous restart)
  // and of the latched mask (used to step through the current scan).
  assign live_first    = CH_W'(next_set_bit(MASK_W'(chan_mask), 6'd0));
  assign live_last     = CH_W'(last_set_bit(MASK_W'(chan_mask)));
  assign scan_next_ptr = CH_W'(next_set_bit(MASK_W'(mask_reg), 6'(ptr_reg) + 6'd1));
  assign is_last       = (ptr_reg == last_reg);

  // Command fields come straight from registers, so they stay put while stalled.
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign cmd_channel = ptr_reg;
  assign cmd_sop     = cmd_valid & sop_reg;
  assign cmd_eop     = cmd_valid & is_last;
  assign busy        = (state_reg != ST_IDLE);

  // Scan state and latched scan context.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg <= ST_IDLE;
      mask_reg  <= '0;
      ptr_reg   <= '0;
      last_reg  <= '0;
      sop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      ptr_reg   <= ptr_next;
      last_reg  <= last_next;
      sop_reg   <= sop_next;
    end
  end

  // Next-state logic: load a scan, step through it, then wait for responses.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    ptr_next   = ptr_reg;
    last_next  = last_reg;
    sop_next   = sop_reg;
    cmd_valid  = 1'b0;
    scan_done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && (|chan_mask)) begin
          mask_next  = chan_mask;
          ptr_next   = live_first;
          last_next  = live_last;
          sop_next   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cmd_valid = ~fifo_full;
        if (cmd_fire) begin
          sop_next = 1'b0;
          if (is_last) state_next = ST_DRAIN;
          else         ptr_next   = scan_next_ptr;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          scan_done = 1'b1;
          if (continuous && (|chan_mask)) begin
            mask_next  = chan_mask;
            ptr_next   = live_first;
            last_next  = live_last;
            sop_next   = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  adc_chan_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (CH_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (cmd_fire),
    .push_data (ptr_reg),
    .pop       (rsp_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A response is wrong if nothing is outstanding or it is not the oldest one.
  assign err_set = rsp_valid & (fifo_empty | (fifo_head != rsp_channel));

  // Response capture and sticky error; a new error beats a same-cycle clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sample_valid_reg   <= 1'b0;
      sample_channel_reg <= '0;
      sample_data_reg    <= '0;
      err_reg            <= 1'b0;
    end else begin
      sample_valid_reg <= rsp_valid;
      if (rsp_valid) begin
        sample_channel_reg <= rsp_channel;
        sample_data_reg    <= rsp_data;
      end
      if (err_set)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
    end
  end

  assign sample_valid   = sample_valid_reg;
  assign sample_channel = sample_channel_reg;
  assign sample_data    = sample_data_reg;
  assign err_mismatch   = err_reg;

  // Out-of-range response channels are still checked but never stored.
  assign rsp_in_range = ({1'b0, rsp_channel} < (CH_W + 1)'(NUM_CH));
  assign rd_in_range  = ({1'b0, rd_addr} < (CH_W + 1)'(NUM_CH));

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank_we
      assign bank_we[gi] = rsp_valid & rsp_in_range & (rsp_channel == CH_W'(gi));
    end
  endgenerate

  // Result bank: latest sample per channel, cleared by reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) bank_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bank_we[i]) bank_reg[i] <= rsp_data;
      end
    end
  end

  assign rd_data = rd_in_range ? bank_reg[rd_addr] : '0;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed self-checking bench for adc_scan_sequencer.
module tb_adc_scan_sequencer;

  localparam int NUM_CH  = 17;
  localparam int MAX_OUT = 4;
  localparam int CH_W    = 5;
  localparam int DATA_W  = 12;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              start;
  logic              continuous;
  logic [NUM_CH-1:0] chan_mask;
  logic              cmd_valid;
  logic [CH_W-1:0]   cmd_channel;
  logic              cmd_sop;
  logic              cmd_eop;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [CH_W-1:0]   rsp_channel;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              scan_done;
  logic              sample_valid;
  logic [CH_W-1:0]   sample_channel;
  logic [DATA_W-1:0] sample_data;
  logic              err_mismatch;
  logic              err_clr;
  logic [CH_W-1:0]   rd_addr;
  logic [DATA_W-1:0] rd_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int rsp_idx  = 0;
  logic [CH_W-1:0] issued [$];

  always #5 clk_clk = ~clk_clk;

  adc_scan_sequencer #(
    .NUM_CH (NUM_CH), .MAX_OUT (MAX_OUT), .CH_W (CH_W), .DATA_W (DATA_W)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .start          (start),
    .continuous     (continuous),
    .chan_mask      (chan_mask),
    .cmd_valid      (cmd_valid),
    .cmd_channel    (cmd_channel),
    .cmd_sop        (cmd_sop),
    .cmd_eop        (cmd_eop),
    .cmd_ready      (cmd_ready),
    .rsp_valid      (rsp_valid),
    .rsp_channel    (rsp_channel),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .scan_done      (scan_done),
    .sample_valid   (sample_valid),
    .sample_channel (sample_channel),
    .sample_data    (sample_data),
    .err_mismatch   (err_mismatch),
    .err_clr        (err_clr),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data)
  );

  // Transaction log: one line per command handshake and per response.
  always @(posedge clk_clk) begin
    if (cmd_valid && cmd_ready) begin
      issued.push_back(cmd_channel);
      acc_cnt++;
      $display("cmd  ch=%0d sop=%0b eop=%0b", cmd_channel, cmd_sop, cmd_eop);
    end
    if (rsp_valid) $display("rsp  ch=%0d data=%h", rsp_channel, rsp_data);
    if (scan_done) begin
      done_cnt++;
      $display("scan_done");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk_clk);
  endtask

  // Answer every issued command in order; stops once the sequencer is idle.
  task automatic respond_all(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (rsp_idx < issued.size()) begin
        rsp_valid   = 1'b1;
        rsp_channel = issued[rsp_idx];
        rsp_data    = 12'hA00 | {7'd0, issued[rsp_idx]};
        rsp_idx++;
      end else begin
        rsp_valid = 1'b0;
      end
      step();
      if (!busy && rsp_idx == issued.size()) break;
    end
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    start = 0; continuous = 0; chan_mask = '0; cmd_ready = 0;
    rsp_valid = 0; rsp_channel = '0; rsp_data = '0; err_clr = 0; rd_addr = '0;
    step(); step();
    vec_cnt++; if (cmd_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if ({cmd_sop, cmd_eop, scan_done, sample_valid} !== 4'b0) begin miss_cnt++; $display("FAIL reset_pulses: got %b want 0000", {cmd_sop, cmd_eop, scan_done, sample_valid}); end
    vec_cnt++; if (err_mismatch !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %b want 0", err_mismatch); end
    vec_cnt++; if (rd_data !== 12'h000) begin miss_cnt++; $display("FAIL reset_rd_data: got %h want 000", rd_data); end
    reset_reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_scan();
    int d0;
    d0 = done_cnt;
    chan_mask = 17'h00005; cmd_ready = 1; start = 1;
    vec_cnt++; if (cmd_valid !== 1'b0) begin miss_cnt++; $display("FAIL single_pre_valid: got %b want 0", cmd_valid); end
    step(); start = 0;
    vec_cnt++; if ({cmd_valid, cmd_channel, cmd_sop, cmd_eop} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin miss_cnt++; $display("FAIL single_cmd0: got v%b ch%0d sop%b eop%b want v1 ch0 sop1 eop0", cmd_valid, cmd_channel, cmd_sop, cmd_eop); end
    step();
    vec_cnt++; if ({cmd_valid, cmd_channel, cmd_sop, cmd_eop} !== {1'b1, 5'd2, 1'b0, 1'b1}) begin miss_cnt++; $display("FAIL single_cmd2: got v%b ch%0d sop%b eop%b want v1 ch2 sop0 eop1", cmd_valid, cmd_channel, cmd_sop, cmd_eop); end
    step();
    vec_cnt++; if ({cmd_valid, busy} !== 2'b01) begin miss_cnt++; $display("FAIL single_drain: got valid=%b busy=%b want valid=0 busy=1", cmd_valid, busy); end
    rsp_valid = 1; rsp_channel = 5'd0; rsp_data = 12'h111;
    step();
    vec_cnt++; if ({sample_valid, sample_channel, sample_data} !== {1'b1, 5'd0, 12'h111}) begin miss_cnt++; $display("FAIL single_sample0: got v%b ch%0d %h want v1 ch0 111", sample_valid, sample_channel, sample_data); end
    vec_cnt++; if (scan_done !== 1'b0) begin miss_cnt++; $display("FAIL single_early_done: got %b want 0", scan_done); end
    rsp_channel = 5'd2; rsp_data = 12'h222;
    step(); rsp_valid = 0;
    vec_cnt++; if ({scan_done, sample_channel, sample_data} !== {1'b1, 5'd2, 12'h222}) begin miss_cnt++; $display("FAIL single_done: got done%b ch%0d %h want done1 ch2 222", scan_done, sample_channel, sample_data); end
    step();
    vec_cnt++; if ({busy, scan_done, sample_valid} !== 3'b000) begin miss_cnt++; $display("FAIL single_idle: got busy%b done%b sv%b want 000", busy, scan_done, sample_valid); end
    rd_addr = 5'd0; #1;
    vec_cnt++; if (rd_data !== 12'h111) begin miss_cnt++; $display("FAIL single_bank0: got %h want 111", rd_data); end
    rd_addr = 5'd2; #1;
    vec_cnt++; if (rd_data !== 12'h222) begin miss_cnt++; $display("FAIL single_bank2: got %h want 222", rd_data); end
    rd_addr = 5'd20; #1;
    vec_cnt++; if (rd_data !== 12'h000) begin miss_cnt++; $display("FAIL single_rd_oob: got %h want 000", rd_data); end
    vec_cnt++; if ((done_cnt - d0) !== 1 || err_mismatch !== 1'b0) begin miss_cnt++; $display("FAIL single_done_cnt: got %0d err%b want 1 err0", done_cnt - d0, err_mismatch); end
    rsp_idx = issued.size();
  endtask

  task automatic test_backpressure();
    int a0;
    chan_mask = 17'h00005; cmd_ready = 1; start = 1;
    step(); start = 0;
    step();
    a0 = acc_cnt;
    cmd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec_cnt++; if ({cmd_valid, cmd_channel, cmd_eop} !== {1'b1, 5'd2, 1'b1}) begin miss_cnt++; $display("FAIL bp_hold%0d: got v%b ch%0d eop%b want v1 ch2 eop1", i, cmd_valid, cmd_channel, cmd_eop); end
    end
    vec_cnt++; if (acc_cnt !== a0) begin miss_cnt++; $display("FAIL bp_no_accept: got %0d accepts want 0", acc_cnt - a0); end
    cmd_ready = 1;
    step();
    step();
    vec_cnt++; if ((acc_cnt - a0) !== 1 || cmd_valid !== 1'b0) begin miss_cnt++; $display("FAIL bp_once: got %0d accepts valid%b want 1 valid0", acc_cnt - a0, cmd_valid); end
    respond_all(20);
    vec_cnt++; if ({busy, err_mismatch} !== 2'b00) begin miss_cnt++; $display("FAIL bp_finish: got busy%b err%b want 00", busy, err_mismatch); end
  endtask

  task automatic test_outstanding();
    int a0, d0;
    d0 = done_cnt;
    chan_mask = 17'h1FFFF; cmd_ready = 1; start = 1;
    a0 = acc_cnt;
    step(); start = 0;
    for (int i = 0; i < 8; i++) step();
    vec_cnt++; if ((acc_cnt - a0) !== 4) begin miss_cnt++; $display("FAIL out_limit: got %0d accepts want 4", acc_cnt - a0); end
    vec_cnt++; if (cmd_valid !== 1'b0) begin miss_cnt++; $display("FAIL out_valid_low: got %b want 0", cmd_valid); end
    rsp_valid = 1; rsp_channel = 5'd0; rsp_data = 12'hA00; rsp_idx++;
    step(); rsp_valid = 0;
    vec_cnt++; if ({cmd_valid, cmd_channel} !== {1'b1, 5'd4}) begin miss_cnt++; $display("FAIL out_resume: got v%b ch%0d want v1 ch4", cmd_valid, cmd_channel); end
    respond_all(200);
    vec_cnt++; if ((acc_cnt - a0) !== 17 || busy !== 1'b0) begin miss_cnt++; $display("FAIL out_total: got %0d accepts busy%b want 17 busy0", acc_cnt - a0, busy); end
    vec_cnt++; if ((done_cnt - d0) !== 1 || err_mismatch !== 1'b0) begin miss_cnt++; $display("FAIL out_done: got %0d err%b want 1 err0", done_cnt - d0, err_mismatch); end
    rd_addr = 5'd16; #1;
    vec_cnt++; if (rd_data !== 12'hA10) begin miss_cnt++; $display("FAIL out_bank16: got %h want A10", rd_data); end
    rd_addr = 5'd1; #1;
    vec_cnt++; if (rd_data !== 12'hA01) begin miss_cnt++; $display("FAIL out_bank1: got %h want A01", rd_data); end
  endtask

  task automatic test_mismatch();
    chan_mask = 17'h00018; cmd_ready = 1; start = 1;
    step(); start = 0;
    step(); step();
    vec_cnt++; if ({busy, cmd_valid} !== 2'b10) begin miss_cnt++; $display("FAIL mm_drain: got busy%b valid%b want 10", busy, cmd_valid); end
    rsp_valid = 1; rsp_channel = 5'd4; rsp_data = 12'hABC;
    step();
    vec_cnt++; if (err_mismatch !== 1'b1) begin miss_cnt++; $display("FAIL mm_err_set: got %b want 1", err_mismatch); end
    vec_cnt++; if ({sample_valid, sample_channel, sample_data} !== {1'b1, 5'd4, 12'hABC}) begin miss_cnt++; $display("FAIL mm_sample: got v%b ch%0d %h want v1 ch4 ABC", sample_valid, sample_channel, sample_data); end
    rd_addr = 5'd4; #1;
    vec_cnt++; if (rd_data !== 12'hABC) begin miss_cnt++; $display("FAIL mm_bank4: got %h want ABC", rd_data); end
    step(); rsp_valid = 0;
    vec_cnt++; if ({scan_done, err_mismatch} !== 2'b11) begin miss_cnt++; $display("FAIL mm_sticky: got done%b err%b want 11", scan_done, err_mismatch); end
    step();
    err_clr = 1;
    step(); err_clr = 0;
    vec_cnt++; if ({busy, err_mismatch} !== 2'b00) begin miss_cnt++; $display("FAIL mm_clear: got busy%b err%b want 00", busy, err_mismatch); end
    rsp_valid = 1; rsp_channel = 5'd0; rsp_data = 12'h5A5; err_clr = 1;
    step(); rsp_valid = 0; err_clr = 0;
    vec_cnt++; if (err_mismatch !== 1'b1) begin miss_cnt++; $display("FAIL mm_err_wins: got %b want 1", err_mismatch); end
    rd_addr = 5'd0; #1;
    vec_cnt++; if (rd_data !== 12'h5A5) begin miss_cnt++; $display("FAIL mm_bank0: got %h want 5A5", rd_data); end
    err_clr = 1;
    step(); err_clr = 0;
    vec_cnt++; if (err_mismatch !== 1'b0) begin miss_cnt++; $display("FAIL mm_clear2: got %b want 0", err_mismatch); end
    rsp_idx = issued.size();
  endtask

  task automatic test_continuous();
    int d0;
    d0 = done_cnt;
    chan_mask = 17'h10000; continuous = 1; cmd_ready = 1; start = 1;
    step(); start = 0;
    vec_cnt++; if ({cmd_valid, cmd_channel, cmd_sop, cmd_eop} !== {1'b1, 5'd16, 1'b1, 1'b1}) begin miss_cnt++; $display("FAIL cont_cmd1: got v%b ch%0d sop%b eop%b want v1 ch16 sop1 eop1", cmd_valid, cmd_channel, cmd_sop, cmd_eop); end
    step();
    rsp_valid = 1; rsp_channel = 5'd16; rsp_data = 12'h161;
    step(); rsp_valid = 0;
    vec_cnt++; if (scan_done !== 1'b1) begin miss_cnt++; $display("FAIL cont_done1: got %b want 1", scan_done); end
    step();
    vec_cnt++; if ({cmd_valid, cmd_sop, cmd_eop, scan_done} !== 4'b1110) begin miss_cnt++; $display("FAIL cont_restart: got v%b sop%b eop%b done%b want 1110", cmd_valid, cmd_sop, cmd_eop, scan_done); end
    step();
    rsp_valid = 1; rsp_data = 12'h162;
    step(); rsp_valid = 0;
    vec_cnt++; if (scan_done !== 1'b1) begin miss_cnt++; $display("FAIL cont_done2: got %b want 1", scan_done); end
    step();
    continuous = 0;
    step();
    rsp_valid = 1; rsp_data = 12'h163;
    step(); rsp_valid = 0;
    vec_cnt++; if (scan_done !== 1'b1) begin miss_cnt++; $display("FAIL cont_done3: got %b want 1", scan_done); end
    step();
    vec_cnt++; if ({busy, cmd_valid} !== 2'b00) begin miss_cnt++; $display("FAIL cont_stop: got busy%b valid%b want 00", busy, cmd_valid); end
    step(); step();
    vec_cnt++; if ((done_cnt - d0) !== 3 || busy !== 1'b0) begin miss_cnt++; $display("FAIL cont_count: got %0d busy%b want 3 busy0", done_cnt - d0, busy); end
    rd_addr = 5'd16; #1;
    vec_cnt++; if (rd_data !== 12'h163) begin miss_cnt++; $display("FAIL cont_bank16: got %h want 163", rd_data); end
    rsp_idx = issued.size();
  endtask

  task automatic test_reset_midscan();
    int a0;
    chan_mask = 17'h00007; cmd_ready = 1; start = 1;
    a0 = acc_cnt;
    step(); start = 0;
    step(); step();
    cmd_ready = 0;
    vec_cnt++; if ((acc_cnt - a0) !== 2) begin miss_cnt++; $display("FAIL rst_outstanding: got %0d want 2", acc_cnt - a0); end
    reset_reset_n = 0; rd_addr = 5'd16; #1;
    vec_cnt++; if ({cmd_valid, cmd_channel, cmd_sop, cmd_eop, busy, scan_done} !== 10'b0) begin miss_cnt++; $display("FAIL rst_cmd_out: got v%b ch%0d sop%b eop%b busy%b done%b want all 0", cmd_valid, cmd_channel, cmd_sop, cmd_eop, busy, scan_done); end
    vec_cnt++; if ({sample_valid, sample_channel, sample_data, err_mismatch} !== 19'b0) begin miss_cnt++; $display("FAIL rst_rsp_out: got sv%b ch%0d %h err%b want all 0", sample_valid, sample_channel, sample_data, err_mismatch); end
    vec_cnt++; if (rd_data !== 12'h000) begin miss_cnt++; $display("FAIL rst_bank: got %h want 000", rd_data); end
    step();
    reset_reset_n = 1;
    step();
    rsp_valid = 1; rsp_channel = 5'd0; rsp_data = 12'h0F0;
    step(); rsp_valid = 0;
    vec_cnt++; if ({err_mismatch, busy, sample_valid} !== 3'b101) begin miss_cnt++; $display("FAIL rst_stray: got err%b busy%b sv%b want 101", err_mismatch, busy, sample_valid); end
    rsp_idx = issued.size();
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_backpressure();
    test_outstanding();
    test_mismatch();
    test_continuous();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
